// File: rtl/llc_snoop_responder_if.sv
// Snoop, tag-array, L1-message and result signals for the LLC snoop responder.
// master: the responder; slave: the bus/tag array/L1 environment around it.
interface llc_snoop_responder_if #(
  parameter int ADDR_SIZE  = 32,
  parameter int N_WAY      = 16,
  parameter int INDEX_SIZE = 14
);
  logic                   snp_valid;
  logic                   snp_ready;
  logic [1:0]             snp_op;
  logic [ADDR_SIZE-1:0]   snp_addr;

  logic                   ta_rd_en;
  logic [INDEX_SIZE-1:0]  ta_rd_index;
  logic [N_WAY*16-1:0]    ta_rd_data;

  logic                   ta_wr_en;
  logic [INDEX_SIZE-1:0]  ta_wr_index;
  logic [3:0]             ta_wr_way;
  logic [15:0]            ta_wr_line;

  logic                   l1_msg_valid;
  logic [1:0]             l1_msg;
  logic [ADDR_SIZE-1:0]   l1_msg_addr;
  logic                   l1_msg_ready;

  logic                   res_valid;
  logic [1:0]             res_result;
  logic                   proto_err;

  modport master (
    input  snp_valid, snp_op, snp_addr, ta_rd_data, l1_msg_ready,
    output snp_ready, ta_rd_en, ta_rd_index, ta_wr_en, ta_wr_index, ta_wr_way,
           ta_wr_line, l1_msg_valid, l1_msg, l1_msg_addr, res_valid, res_result,
           proto_err
  );

  modport slave (
    output snp_valid, snp_op, snp_addr, ta_rd_data, l1_msg_ready,
    input  snp_ready, ta_rd_en, ta_rd_index, ta_wr_en, ta_wr_index, ta_wr_way,
           ta_wr_line, l1_msg_valid, l1_msg, l1_msg_addr, res_valid, res_result,
           proto_err
  );
endinterface

// File: rtl/llc_snoop_responder.sv
// MESI snoop responder: tag lookup, state update, L1 messaging, result pulse.
// Result 3 cycles after accept plus one or more per L1 message; one snoop in flight, L1 stalls hold the FSM in MSG.
module llc_snoop_responder #(
  parameter int ADDR_SIZE   = 32,
  parameter int N_WAY       = 16,
  parameter int INDEX_SIZE  = 14,
  parameter int TAG_SIZE    = 12,
  parameter int OFFSET_SIZE = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  llc_snoop_responder_if.master bus
);
  localparam int LINE_W = ADDR_SIZE - OFFSET_SIZE;

  localparam logic [1:0] OP_READ   = 2'd0;
  localparam logic [1:0] OP_WRITE  = 2'd1;
  localparam logic [1:0] OP_RWIM   = 2'd2;
  localparam logic [1:0] OP_INV    = 2'd3;
  localparam logic [1:0] MESI_M    = 2'd0;
  localparam logic [1:0] MESI_S    = 2'd2;
  localparam logic [1:0] MESI_I    = 2'd3;
  localparam logic [1:0] MSG_GET   = 2'd0;
  localparam logic [1:0] MSG_INV   = 2'd2;
  localparam logic [1:0] RES_HIT   = 2'd0;
  localparam logic [1:0] RES_HITM  = 2'd1;
  localparam logic [1:0] RES_NOHIT = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EVAL, S_MSG, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                inv_pend_q, inv_pend_d;
  logic                err_q, err_d;
  logic [1:0]          res_q, res_d;
  logic                snp_ready_q, snp_ready_d;
  logic                ta_rd_en_q, ta_rd_en_d;
  logic                ta_wr_en_q, ta_wr_en_d;
  logic [3:0]          ta_wr_way_q, ta_wr_way_d;
  logic [15:0]         ta_wr_line_q, ta_wr_line_d;
  logic                l1_msg_valid_q, l1_msg_valid_d;
  logic [1:0]          l1_msg_q, l1_msg_d;
  logic                res_valid_q, res_valid_d;
  logic                proto_err_q, proto_err_d;

  logic [TAG_SIZE-1:0] snp_tag;
  logic                hit;
  logic [3:0]          hit_way;
  logic [15:0]         hit_line;

  assign snp_tag = line_q[LINE_W-1 -: TAG_SIZE];

  // Lowest matching way wins; invalid or I-state entries never hit.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    hit_line = '0;
    for (int w = 0; w < N_WAY; w++) begin
      if (!hit && bus.ta_rd_data[16*w+12] && (bus.ta_rd_data[16*w+14 +: 2] != MESI_I) &&
          (bus.ta_rd_data[16*w +: TAG_SIZE] == snp_tag)) begin
        hit      = 1'b1;
        hit_way  = 4'(w);
        hit_line = bus.ta_rd_data[16*w +: 16];
      end
    end
  end

  logic [1:0]  act_res;
  logic        act_err, act_get, act_inv, act_upd;
  logic [1:0]  new_mesi;
  logic        new_dirty, new_valid;
  logic [15:0] new_line;

  always_comb begin
    act_res   = RES_NOHIT;
    act_err   = 1'b0;
    act_get   = 1'b0;
    act_inv   = 1'b0;
    new_mesi  = hit_line[15:14];
    new_dirty = hit_line[13];
    new_valid = hit_line[12];
    if (hit) begin
      case (op_q)
        OP_READ: begin
          new_mesi = MESI_S;
          if (hit_line[15:14] == MESI_M) begin
            act_res   = RES_HITM;
            new_dirty = 1'b0;
            act_get   = 1'b1;
          end else begin
            act_res = RES_HIT;
          end
        end
        OP_WRITE: act_err = 1'b1;
        OP_RWIM: begin
          act_res  = (hit_line[15:14] == MESI_M) ? RES_HITM : RES_HIT;
          act_get  = (hit_line[15:14] == MESI_M);
          act_inv  = 1'b1;
          new_mesi = MESI_I;
        end
        default: begin
          if (hit_line[15:14] == MESI_S) begin
            act_res  = RES_HIT;
            act_inv  = 1'b1;
            new_mesi = MESI_I;
          end else begin
            act_err = 1'b1;
          end
        end
      endcase
    end
    if (new_mesi == MESI_I) begin
      new_valid = 1'b0;
      new_dirty = 1'b0;
    end
    new_line = {new_mesi, new_dirty, new_valid, hit_line[11:0]};
    // Only a real change costs a tag write (READ of an S line leaves it alone).
    act_upd  = hit && (new_line != hit_line);
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    line_d         = line_q;
    inv_pend_d     = inv_pend_q;
    err_d          = err_q;
    res_d          = res_q;
    snp_ready_d    = 1'b0;
    ta_rd_en_d     = 1'b0;
    ta_wr_en_d     = 1'b0;
    ta_wr_way_d    = ta_wr_way_q;
    ta_wr_line_d   = ta_wr_line_q;
    l1_msg_valid_d = 1'b0;
    l1_msg_d       = l1_msg_q;
    res_valid_d    = 1'b0;
    proto_err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        snp_ready_d = 1'b1;
        if (bus.snp_valid) begin
          op_d        = bus.snp_op;
          line_d      = bus.snp_addr[ADDR_SIZE-1:OFFSET_SIZE];
          snp_ready_d = 1'b0;
          ta_rd_en_d  = 1'b1;
          state_d     = S_READ;
        end
      end
      S_READ: state_d = S_EVAL;
      S_EVAL: begin
        res_d        = act_res;
        err_d        = act_err;
        ta_wr_en_d   = act_upd;
        ta_wr_way_d  = hit_way;
        ta_wr_line_d = new_line;
        if (act_get || act_inv) begin
          l1_msg_valid_d = 1'b1;
          l1_msg_d       = act_get ? MSG_GET : MSG_INV;
          inv_pend_d     = act_get && act_inv;
          state_d        = S_MSG;
        end else begin
          res_valid_d = 1'b1;
          proto_err_d = act_err;
          state_d     = S_RESP;
        end
      end
      S_MSG: begin
        l1_msg_valid_d = 1'b1;
        if (bus.l1_msg_ready) begin
          if (inv_pend_q) begin
            l1_msg_d   = MSG_INV;
            inv_pend_d = 1'b0;
          end else begin
            l1_msg_valid_d = 1'b0;
            res_valid_d    = 1'b1;
            proto_err_d    = err_q;
            state_d        = S_RESP;
          end
        end
      end
      default: begin
        snp_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      op_q           <= '0;
      line_q         <= '0;
      inv_pend_q     <= 1'b0;
      err_q          <= 1'b0;
      res_q          <= '0;
      snp_ready_q    <= 1'b1;
      ta_rd_en_q     <= 1'b0;
      ta_wr_en_q     <= 1'b0;
      ta_wr_way_q    <= '0;
      ta_wr_line_q   <= '0;
      l1_msg_valid_q <= 1'b0;
      l1_msg_q       <= '0;
      res_valid_q    <= 1'b0;
      proto_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      line_q         <= line_d;
      inv_pend_q     <= inv_pend_d;
      err_q          <= err_d;
      res_q          <= res_d;
      snp_ready_q    <= snp_ready_d;
      ta_rd_en_q     <= ta_rd_en_d;
      ta_wr_en_q     <= ta_wr_en_d;
      ta_wr_way_q    <= ta_wr_way_d;
      ta_wr_line_q   <= ta_wr_line_d;
      l1_msg_valid_q <= l1_msg_valid_d;
      l1_msg_q       <= l1_msg_d;
      res_valid_q    <= res_valid_d;
      proto_err_q    <= proto_err_d;
    end
  end

  assign bus.snp_ready    = snp_ready_q;
  assign bus.ta_rd_en     = ta_rd_en_q;
  assign bus.ta_rd_index  = line_q[INDEX_SIZE-1:0];
  assign bus.ta_wr_en     = ta_wr_en_q;
  assign bus.ta_wr_index  = line_q[INDEX_SIZE-1:0];
  assign bus.ta_wr_way    = ta_wr_way_q;
  assign bus.ta_wr_line   = ta_wr_line_q;
  assign bus.l1_msg_valid = l1_msg_valid_q;
  assign bus.l1_msg       = l1_msg_q;
  assign bus.l1_msg_addr  = {line_q, {OFFSET_SIZE{1'b0}}};
  assign bus.res_valid    = res_valid_q;
  assign bus.res_result   = res_q;
  assign bus.proto_err    = proto_err_q;
endmodule

// File: tb/tb_llc_snoop_responder.sv
// Bench for llc_snoop_responder: table of snoops against constructed sets, scoreboarded events, reset corners.
module tb_llc_snoop_responder;
  localparam int AW = 32;
  localparam int NW = 16;
  localparam int IW = 14;
  localparam int TW = 12;
  localparam int OW = 6;

  localparam logic [1:0] OP_READ = 2'd0, OP_WRITE = 2'd1, OP_RWIM = 2'd2, OP_INV = 2'd3;
  localparam logic [1:0] M = 2'd0, E = 2'd1, S = 2'd2, I = 2'd3;
  localparam logic [1:0] HIT = 2'd0, HITM = 2'd1, NOHIT = 2'd2;
  localparam logic [1:0] GETLINE = 2'd0, INVLINE = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  llc_snoop_responder_if #(.ADDR_SIZE(AW), .N_WAY(NW), .INDEX_SIZE(IW)) bus ();

  llc_snoop_responder #(
    .ADDR_SIZE(AW), .N_WAY(NW), .INDEX_SIZE(IW), .TAG_SIZE(TW), .OFFSET_SIZE(OW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef enum int {EV_WR, EV_MSG, EV_RES} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] tag;
    logic [13:0] idx;
    int          way;
    logic [1:0]  mesi;
    logic        dirty;
    logic        tvalid;
    int          way2;
    logic [1:0]  mesi2;
    logic        empty;
    logic [1:0]  res;
    logic        err;
    logic        wr;
    logic [1:0]  nmesi;
    logic        ndirty;
    logic        nvalid;
    logic        get;
    logic        inv;
    int          stall;
  } vec_t;

  ev_t             exp_q[$];
  int              total = 0;
  int              bad = 0;
  int              cyc = 0;
  logic [NW*16-1:0] cur_set = '0;
  logic            rd_seen = 1'b0;
  int              stall_left = 0;
  int              acc_cyc = 0;
  int              exp_lat = 0;
  int              res_cnt = 0;
  int              rd_cnt = 0;
  logic [13:0]     exp_idx = '0;
  logic            held_vld = 1'b0;
  logic [1:0]      held_msg = '0;
  logic [31:0]     held_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endfunction

  function automatic void push_ev(ev_kind_t k, logic [31:0] a, logic [31:0] b);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.b    = b;
    exp_q.push_back(e);
  endfunction

  function automatic void expect_ev(string name, ev_kind_t k, logic [31:0] a, logic [31:0] b);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s: got a=%0h b=%0h required no event", name, a, b);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind !== k || e.a !== a || e.b !== b) begin
      bad++;
      $display("FAIL event_%s: got kind=%0d a=%0h b=%0h required kind=%0d a=%0h b=%0h",
               name, k, a, b, e.kind, e.a, e.b);
    end
  endfunction

  // Tag-array and L1 models plus the output monitor, all on the falling edge.
  always @(negedge clk) begin
    bus.ta_rd_data = rd_seen ? cur_set : '0;
    rd_seen = bus.ta_rd_en;
    if (bus.l1_msg_valid && stall_left > 0) begin
      bus.l1_msg_ready = 1'b0;
      stall_left--;
    end else begin
      bus.l1_msg_ready = 1'b1;
    end

    if (bus.snp_valid && bus.snp_ready) acc_cyc = cyc;
    if (bus.ta_rd_en) begin
      rd_cnt++;
      check("rd_index", 32'(bus.ta_rd_index), 32'(exp_idx));
    end
    if (bus.l1_msg_valid && !bus.l1_msg_ready) begin
      if (held_vld) begin
        check("msg_hold", 32'(bus.l1_msg), 32'(held_msg));
        check("msg_hold_addr", bus.l1_msg_addr, held_addr);
      end
      held_vld  = 1'b1;
      held_msg  = bus.l1_msg;
      held_addr = bus.l1_msg_addr;
    end else begin
      held_vld = 1'b0;
    end
    if (bus.ta_wr_en)
      expect_ev("wr", EV_WR, {12'b0, bus.ta_wr_way, bus.ta_wr_line}, 32'(bus.ta_wr_index));
    if (bus.l1_msg_valid && bus.l1_msg_ready)
      expect_ev("msg", EV_MSG, 32'(bus.l1_msg), bus.l1_msg_addr);
    if (bus.proto_err) check("err_with_res", 32'(bus.res_valid), 32'd1);
    if (bus.res_valid) begin
      expect_ev("res", EV_RES, 32'(bus.res_result), 32'(bus.proto_err));
      check("latency", 32'(cyc - acc_cyc), 32'(exp_lat));
      res_cnt++;
    end
  end

  task automatic build_set(input vec_t v);
    logic [11:0] t;
    for (int w = 0; w < NW; w++) begin
      t = v.tag ^ 12'(w + 1);
      cur_set[16*w +: 16] = v.empty ? 16'h0 : {2'(w % 3), 1'b0, 1'b1, t};
    end
    if (v.way >= 0)  cur_set[16*v.way +: 16]  = {v.mesi, v.dirty, v.tvalid, v.tag};
    if (v.way2 >= 0) cur_set[16*v.way2 +: 16] = {v.mesi2, 1'b0, 1'b1, v.tag};
  endtask

  task automatic launch(input vec_t v, output logic ok);
    logic [31:0] addr;
    addr = {v.tag, v.idx, 6'b0};
    build_set(v);
    exp_idx = v.idx;
    if (v.wr) push_ev(EV_WR, {12'b0, 4'(v.way), v.nmesi, v.ndirty, v.nvalid, v.tag}, 32'(v.idx));
    if (v.get) push_ev(EV_MSG, 32'(GETLINE), addr);
    if (v.inv) push_ev(EV_MSG, 32'(INVLINE), addr);
    push_ev(EV_RES, 32'(v.res), 32'(v.err));
    exp_lat    = 3 + int'(v.get) + int'(v.inv) + v.stall;
    stall_left = v.stall;
    rd_cnt     = 0;
    ok         = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk);
      #1;
      ok = bus.snp_ready;
    end
    if (!ok) begin
      check("ready_timeout", 32'(bus.snp_ready), 32'd1);
      return;
    end
    bus.snp_op    = v.op;
    bus.snp_addr  = addr;
    bus.snp_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.snp_valid = 1'b0;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int r0;
    logic ok;
    r0 = res_cnt;
    launch(v, ok);
    if (ok) begin
      for (int i = 0; i < 60 && res_cnt == r0; i++) @(posedge clk);
      #1;
      check({"done_", name}, 32'(res_cnt - r0), 32'd1);
      check({"leftover_", name}, 32'(exp_q.size()), 32'd0);
      check({"rd_pulses_", name}, 32'(rd_cnt), 32'd1);
    end
    exp_q.delete();
  endtask

  vec_t vecs[16];
  vec_t rv;
  logic ok_r;

  initial begin
    //             op        tag       idx       way mesi dirty tval  way2 m2 empty res    err   wr    nmesi ndir  nval  get   inv  stall
    vecs[0]  = '{OP_READ,  12'h0AB, 14'h0123,  5, M, 1'b1, 1'b1, -1, M, 1'b0, HITM,  1'b0, 1'b1, S, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    vecs[1]  = '{OP_READ,  12'h111, 14'h0010,  2, E, 1'b0, 1'b1, -1, M, 1'b0, HIT,   1'b0, 1'b1, S, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[2]  = '{OP_READ,  12'h222, 14'h0020,  7, S, 1'b0, 1'b1, -1, M, 1'b0, HIT,   1'b0, 1'b0, S, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[3]  = '{OP_WRITE, 12'h333, 14'h0030,  3, S, 1'b0, 1'b1, -1, M, 1'b0, NOHIT, 1'b1, 1'b0, S, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[4]  = '{OP_RWIM,  12'h444, 14'h0040,  0, S, 1'b0, 1'b1, -1, M, 1'b0, HIT,   1'b0, 1'b1, I, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[5]  = '{OP_RWIM,  12'h555, 14'h0050,  9, E, 1'b0, 1'b1, -1, M, 1'b0, HIT,   1'b0, 1'b1, I, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[6]  = '{OP_RWIM,  12'h666, 14'h0060, 15, M, 1'b1, 1'b1, -1, M, 1'b0, HITM,  1'b0, 1'b1, I, 1'b0, 1'b0, 1'b1, 1'b1, 4};
    vecs[7]  = '{OP_INV,   12'h777, 14'h0070,  4, S, 1'b0, 1'b1, -1, M, 1'b0, HIT,   1'b0, 1'b1, I, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[8]  = '{OP_INV,   12'h888, 14'h0080,  1, E, 1'b0, 1'b1, -1, M, 1'b0, NOHIT, 1'b1, 1'b0, E, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[9]  = '{OP_INV,   12'h999, 14'h0090,  6, M, 1'b1, 1'b1, -1, M, 1'b0, NOHIT, 1'b1, 1'b0, M, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[10] = '{OP_READ,  12'hAAA, 14'h3FFF, -1, M, 1'b0, 1'b1, -1, M, 1'b1, NOHIT, 1'b0, 1'b0, M, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[11] = '{OP_READ,  12'hBBB, 14'h00B0, 10, I, 1'b0, 1'b1, -1, M, 1'b0, NOHIT, 1'b0, 1'b0, M, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[12] = '{OP_READ,  12'hCCC, 14'h00C0, 11, S, 1'b0, 1'b0, -1, M, 1'b0, NOHIT, 1'b0, 1'b0, M, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[13] = '{OP_READ,  12'hDDD, 14'h00D0,  3, E, 1'b0, 1'b1,  8, M, 1'b0, HIT,   1'b0, 1'b1, S, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[14] = '{OP_WRITE, 12'hEEE, 14'h00E0, -1, M, 1'b0, 1'b1, -1, M, 1'b0, NOHIT, 1'b0, 1'b0, M, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[15] = '{OP_RWIM,  12'hFFF, 14'h00F0, 12, M, 1'b1, 1'b1, -1, M, 1'b0, HITM,  1'b0, 1'b1, I, 1'b0, 1'b0, 1'b1, 1'b1, 0};

    bus.snp_valid    = 1'b0;
    bus.snp_op       = '0;
    bus.snp_addr     = '0;
    bus.l1_msg_ready = 1'b1;
    bus.ta_rd_data   = '0;

    #12;
    check("rst_snp_ready", 32'(bus.snp_ready), 32'd1);
    check("rst_strobes", {27'b0, bus.ta_rd_en, bus.ta_wr_en, bus.l1_msg_valid, bus.res_valid, bus.proto_err}, 32'd0);
    check("rst_wr_line", 32'(bus.ta_wr_line), 32'd0);
    check("rst_msg_addr", bus.l1_msg_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 16; k++) run_vec($sformatf("v%0d", k), vecs[k]);

    // Reset while a GETLINE is stalled: the snoop must vanish without trace.
    rv = vecs[15];
    rv.tag = 12'h3C5;
    rv.idx = 14'h2A1;
    rv.way = 2;
    rv.stall = 30;
    launch(rv, ok_r);
    for (int i = 0; i < 20 && !bus.l1_msg_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check("mid_msg_seen", 32'(bus.l1_msg_valid), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("mid_pending", 32'(exp_q.size()), 32'd3);
    rst = 1'b1;
    #1;
    exp_q.delete();
    stall_left = 0;
    check("mid_rst_ready", 32'(bus.snp_ready), 32'd1);
    check("mid_rst_outs", {27'b0, bus.ta_rd_en, bus.ta_wr_en, bus.l1_msg_valid, bus.res_valid, bus.proto_err}, 32'd0);
    check("mid_rst_msg_addr", bus.l1_msg_addr, 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst_ready_edge", 32'(bus.snp_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_quiet", {28'b0, bus.snp_ready, bus.ta_wr_en, bus.l1_msg_valid, bus.res_valid}, 32'h8);
    end

    run_vec("recover", vecs[1]);
    run_vec("recover_m", vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end
endmodule
